// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states and requester indices.
// Pure declarations; no logic, no latency.
// Backpressure is handled by the modules that import this package.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam int REQ_IFETCH = 0;
    localparam int REQ_LSU    = 1;
    localparam int REQ_VLSU   = 2;

    // Width of a requester index; never below one bit so ports stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first requester after rr_ptr (mod NREQ) wins.
// Purely combinational, zero latency.
// No backpressure; the caller decides when to honour the result.
module rr_priority_picker #(
    parameter int NREQ  = 3,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_vld
);

    logic [IDX_W-1:0] cand;

    // Walk the ring starting just past rr_ptr; the first set request wins.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NREQ);
            if (!win_vld && req[cand]) begin
                win_vld      = 1'b1;
                win_idx      = cand;
                win_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharer of one memory port among NREQ masters; read bursts go one beat at a time. Optional MPA_LOCK_EN keeps a locked master.
// Latency: req -> gnt and req -> mem_valid 1 cycle; read data passes through combinationally; one idle bubble after completion.
// Backpressure: command held on mem_valid until mem_ready; one read beat outstanding; other requests wait while busy.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    input  logic [NREQ*DATA_W/8-1:0] req_wstrb,
    input  logic [NREQ*LEN_W-1:0]    req_len,
    input  logic [NREQ-1:0]          req_lock,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          rsp_valid,
    output logic                     rsp_last,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     busy,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [DATA_W/8-1:0]      mem_wstrb,
    input  logic                     mem_rvalid,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int                IDX_W  = idx_width(NREQ);
    localparam int                STRB_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(STRB_W);
    localparam logic [IDX_W-1:0]  RR_RST = IDX_W'(NREQ - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [LEN_W-1:0]    beat_q, beat_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;

    logic [NREQ-1:0]     pick_oh;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_vld;

    logic [IDX_W-1:0]    cap_idx;
    logic                cap_we;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;
    logic [STRB_W-1:0]   cap_wstrb;
    logic [LEN_W-1:0]    cap_len;

    logic [NREQ-1:0]     win_oh;
    logic                load_cmd;
    logic                rd_beat;
    logic                rd_last;
    logic                wr_done;
    logic                xfer_done;
    logic                relock;

    rr_priority_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .win_vld (pick_vld)
    );

`ifdef MPA_LOCK_EN
    // A locked master still requesting at completion keeps the port for its next command.
    assign relock = req_lock[win_q] & req[win_q];
`else
    logic unused_lock;
    assign relock      = 1'b0;
    assign unused_lock = ^req_lock;
`endif

    // Command fields of the master being granted: the RR winner in IDLE, else the current owner (relock).
    always_comb begin
        cap_idx   = (state_q == S_IDLE) ? pick_idx : win_q;
        cap_we    = 1'b0;
        cap_addr  = '0;
        cap_wdata = '0;
        cap_wstrb = '0;
        cap_len   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (cap_idx == IDX_W'(i)) begin
                cap_we    = req_we[i];
                cap_addr  = req_addr[i*ADDR_W +: ADDR_W];
                cap_wdata = req_wdata[i*DATA_W +: DATA_W];
                cap_wstrb = req_wstrb[i*STRB_W +: STRB_W];
                cap_len   = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // One-hot form of the current owner for response routing and regrant.
    always_comb begin
        win_oh        = '0;
        win_oh[win_q] = 1'b1;
    end

    // Memory command drive and response routing; read data is a straight pass-through.
    always_comb begin
        mem_valid = (state_q == S_ISSUE);
        mem_we    = mem_valid & we_q;
        mem_addr  = mem_valid ? (addr_q + ADDR_W'(beat_q) * STRIDE) : '0;
        mem_wdata = (mem_valid & we_q) ? wdata_q : '0;
        mem_wstrb = (mem_valid & we_q) ? wstrb_q : '0;
        wr_done   = mem_valid & mem_ready & we_q;
        rd_beat   = (state_q == S_WAIT) & mem_rvalid;
        rd_last   = rd_beat & (beat_q == len_q);
        xfer_done = wr_done | rd_last;
        rsp_valid = (wr_done | rd_beat) ? win_oh : '0;
        rsp_last  = xfer_done;
        rsp_data  = rd_beat ? mem_rdata : '0;
        busy      = (state_q != S_IDLE);
    end

    assign gnt = gnt_q;

    // Next-state: arbitrate in IDLE, issue beats, count reads; completion returns to IDLE unless relocked.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        beat_d   = beat_q;
        len_d    = len_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        gnt_d    = '0;
        load_cmd = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    load_cmd = 1'b1;
                    gnt_d    = pick_oh;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_ready) begin
                    state_d = we_q ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    if (beat_q == len_q) begin
                        state_d = S_IDLE;
                    end else begin
                        // beat < len here, so the counter never wraps even at len = 2^LEN_W-1
                        beat_d  = beat_q + LEN_W'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (xfer_done) begin
            if (relock) begin
                load_cmd = 1'b1;
                gnt_d    = win_oh;
                state_d  = S_ISSUE;
            end else begin
                rr_ptr_d = win_q;
            end
        end

        if (load_cmd) begin
            win_d   = cap_idx;
            we_d    = cap_we;
            addr_d  = cap_addr;
            wdata_d = cap_wdata;
            wstrb_d = cap_wstrb;
            // writes are always a single beat regardless of the len field
            len_d   = cap_we ? '0 : cap_len;
            beat_d  = '0;
        end
    end

    // State and command registers; reset drops any in-flight transfer on the spot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= RR_RST;
            win_q    <= '0;
            beat_q   <= '0;
            len_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            gnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            beat_q   <= beat_d;
            len_q    <= len_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            gnt_q    <= gnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run.
// Expected behaviour comes from a transaction-level model of the arbitration and burst rules.
// Inputs change 1 time unit after the rising edge, outputs are sampled 3 units after it.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  req, req_we, req_lock, gnt, rsp_valid;
    logic [95:0] req_addr, req_wdata;
    logic [11:0] req_wstrb, req_len;
    logic        rsp_last, busy, mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] rsp_data, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .resetn(resetn), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_len(req_len), .req_lock(req_lock),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_data(rsp_data), .busy(busy),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int n_chk = 0, n_pass = 0, n_fail = 0;

    // master-side command registers
    logic [2:0]  m_req = '0, m_we = '0, m_lock = '0, drop_mask = '0;
    logic [31:0] m_addr [3];
    logic [31:0] m_wdata [3];
    logic [3:0]  m_wstrb [3];
    logic [3:0]  m_len [3];

    // knobs
    bit rnd_req = 0, rnd_ready = 0, stray = 0, keep_req = 0;
    int ready_low = 0, rv_min = 0, rv_max = 0;

    // transaction-level model
    int          last = 2, phase = 0, cur = 0, beat = 0, nbeats = 0, rv_cnt = -1, force_w = -1;
    int          done_cnt = 0, obs_rsp = 0, obs_last = 0, obs_mv = 0;
    bit          idle_prev = 1, cur_we = 0;
    logic [31:0] base = '0, cwdata = '0, rv_data = '0;
    logic [3:0]  cwstrb = '0;
    logic [2:0]  prev_req = '0;
    int          gq [$];
    logic [31:0] aq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memval(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    // first requester strictly after the last served one, wrapping around
    function automatic int rr_pick(input logic [2:0] r, input int l);
        for (int k = 1; k <= 3; k++) if (r[(l + k) % 3]) return (l + k) % 3;
        return -1;
    endfunction

    function automatic int gq_at(input int i);
        return (gq.size() > i) ? gq[i] : -1;
    endfunction

    function automatic logic [31:0] aq_at(input int i);
        return (aq.size() > i) ? aq[i] : 32'hDEAD_0000;
    endfunction

    task automatic set_cmd(input int i, input bit we, input logic [31:0] a, input logic [3:0] l,
                           input logic [31:0] wd, input logic [3:0] ws);
        m_req[i] = 1'b1; m_we[i] = we; m_addr[i] = a; m_len[i] = l; m_wdata[i] = wd; m_wstrb[i] = ws;
    endtask

    task automatic new_cmd(input int i);
        logic [31:0] a;
        a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 | ($urandom & 32'h3C)) : ($urandom & 32'hFFFF_FFFC);
        set_cmd(i, ($urandom_range(0, 2) == 0), a, 4'($urandom), $urandom, 4'($urandom));
    endtask

    task automatic drive_ports();
        for (int i = 0; i < 3; i++) begin
            req[i] = m_req[i]; req_we[i] = m_we[i]; req_lock[i] = m_lock[i];
            req_addr[i*32 +: 32] = m_addr[i]; req_wdata[i*32 +: 32] = m_wdata[i];
            req_wstrb[i*4 +: 4] = m_wstrb[i]; req_len[i*4 +: 4] = m_len[i];
        end
    endtask

    task automatic model_reset();
        last = 2; phase = 0; rv_cnt = -1; force_w = -1; idle_prev = 1; prev_req = '0; drop_mask = '0;
    endtask

    // One clock of stimulus plus checking of every output against the model.
    task automatic cycle();
        logic [2:0]  exp_gnt, exp_rv;
        logic        exp_last;
        logic [31:0] exp_data;
        int          ph0, w;
        bit          done;
        @(posedge clk); #1;
        m_req = m_req & ~drop_mask;
        drop_mask = '0;
        exp_gnt = '0;
        w = -1;
        if (force_w >= 0) w = force_w;
        else if (idle_prev && prev_req != 0) w = rr_pick(prev_req, last);
        force_w = -1;
        if (w >= 0) begin
            exp_gnt = 3'(1 << w);
            gq.push_back(w);
            cur = w; phase = 1; beat = 0; cur_we = m_we[w]; base = m_addr[w];
            cwdata = m_wdata[w]; cwstrb = m_wstrb[w];
            nbeats = m_we[w] ? 1 : int'(m_len[w]) + 1;
            if (!(keep_req || (rnd_req && $urandom_range(0, 3) == 0))) drop_mask[w] = 1'b1;
        end
        if (rnd_req) begin
            for (int i = 0; i < 3; i++) if (!m_req[i] && $urandom_range(0, 3) == 0) new_cmd(i);
            m_lock = 3'($urandom);
        end
        if (ready_low > 0 && phase == 1) begin
            mem_ready = 1'b0; ready_low--;
        end else begin
            mem_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        if (rv_cnt == 0) begin
            mem_rvalid = 1'b1; mem_rdata = rv_data;
        end else if (stray && phase != 2 && $urandom_range(0, 7) == 0) begin
            mem_rvalid = 1'b1; mem_rdata = $urandom;
        end else begin
            mem_rvalid = 1'b0; mem_rdata = $urandom;
        end
        drive_ports();
        #2;
        ph0 = phase;
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        chk("busy", 32'(busy), 32'(ph0 != 0));
        chk("mem_valid", 32'(mem_valid), 32'(ph0 == 1));
        if (mem_valid) obs_mv++;
        if (rsp_valid != 0) obs_rsp++;
        if (rsp_last) obs_last++;
        if (ph0 == 1) begin
            chk("mem_addr", mem_addr, base + 32'(beat) * 32'd4);
            chk("mem_we", 32'(mem_we), 32'(cur_we));
            if (cur_we) begin
                chk("mem_wdata", mem_wdata, cwdata);
                chk("mem_wstrb", 32'(mem_wstrb), 32'(cwstrb));
            end
        end
        exp_rv = '0; exp_last = 1'b0; exp_data = '0; done = 0;
        if (ph0 == 2 && mem_rvalid) begin
            exp_rv = 3'(1 << cur); exp_data = rv_data; beat++; rv_cnt = -1;
            if (beat == nbeats) begin exp_last = 1'b1; done = 1; end
            else phase = 1;
        end else if (ph0 == 2 && rv_cnt > 0) begin
            rv_cnt--;
        end
        if (ph0 == 1 && mem_ready) begin
            aq.push_back(base + 32'(beat) * 32'd4);
            if (cur_we) begin
                exp_rv = 3'(1 << cur); exp_last = 1'b1; done = 1;
            end else begin
                phase = 2; rv_data = memval(base + 32'(beat) * 32'd4);
                rv_cnt = $urandom_range(rv_min, rv_max);
            end
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        chk("rsp_last", 32'(rsp_last), 32'(exp_last));
        if (exp_rv != 0) chk("rsp_data", rsp_data, exp_data);
        if (done) begin
            phase = 0; done_cnt++;
`ifdef MPA_LOCK_EN
            if (req_lock[cur] && req[cur]) force_w = cur;
            else last = cur;
`else
            last = cur;
`endif
        end
        idle_prev = (ph0 == 0);
        prev_req = req;
    endtask

    initial begin
        int n, d0;
        for (int i = 0; i < 3; i++) set_cmd(i, 0, '0, '0, '0, '0);
        m_req = '0;
        resetn = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        drive_ports();
        repeat (2) @(posedge clk);
        #3;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_valid", 32'(mem_valid), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_last", 32'(rsp_last), 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        model_reset();

        // all three masters hold len=0 reads: grants 0,1,2,0 with a bubble between
        keep_req = 1; rv_min = 0; rv_max = 1;
        set_cmd(0, 0, 32'h10, 4'd0, '0, '0);
        set_cmd(1, 0, 32'h20, 4'd0, '0, '0);
        set_cmd(2, 0, 32'h30, 4'd0, '0, '0);
        gq.delete();
        repeat (24) cycle();
        chk("order0", 32'(gq_at(0)), 0);
        chk("order1", 32'(gq_at(1)), 1);
        chk("order2", 32'(gq_at(2)), 2);
        chk("order3", 32'(gq_at(3)), 0);
        keep_req = 0; m_req = '0;
        repeat (6) cycle();

        // single read from master 1, data two cycles after accept
        rv_min = 1; rv_max = 1; gq.delete(); obs_last = 0; d0 = done_cnt;
        set_cmd(1, 0, 32'h100, 4'd0, '0, '0);
        repeat (2) cycle();
        chk("single_gnt", 32'(gq_at(0)), 1);
        repeat (6) cycle();
        chk("single_done", 32'(done_cnt - d0), 1);
        chk("single_last", 32'(obs_last), 1);

        // len=3 burst crossing the top of the address space
        rnd_ready = 1; rv_min = 0; rv_max = 2; aq.delete(); obs_rsp = 0; obs_last = 0; d0 = done_cnt;
        set_cmd(2, 0, 32'hFFFF_FFF8, 4'd3, '0, '0);
        n = 0;
        while (done_cnt == d0 && n < 80) begin cycle(); n++; end
        chk("wrap_done", 32'(done_cnt - d0), 1);
        chk("wrap_a0", aq_at(0), 32'hFFFF_FFF8);
        chk("wrap_a1", aq_at(1), 32'hFFFF_FFFC);
        chk("wrap_a2", aq_at(2), 32'h0000_0000);
        chk("wrap_a3", aq_at(3), 32'h0000_0004);
        chk("wrap_beats", 32'(obs_rsp), 4);
        chk("wrap_last", 32'(obs_last), 1);
        repeat (2) cycle();

        // write stalled by mem_ready low for five cycles
        rnd_ready = 0; obs_mv = 0; d0 = done_cnt;
        set_cmd(1, 1, 32'h40, 4'd9, 32'hDEAD_BEEF, 4'b0011);
        ready_low = 5;
        n = 0;
        while (done_cnt == d0 && n < 30) begin cycle(); n++; end
        chk("wr_done", 32'(done_cnt - d0), 1);
        chk("wr_hold_cycles", 32'(obs_mv), 6);
        repeat (2) cycle();

        // maximum burst: 16 beats, last only once
        rnd_ready = 1; obs_rsp = 0; obs_last = 0; d0 = done_cnt;
        set_cmd(0, 0, 32'h1000, 4'hF, '0, '0);
        n = 0;
        while (done_cnt == d0 && n < 200) begin cycle(); n++; end
        chk("max_done", 32'(done_cnt - d0), 1);
        chk("max_beats", 32'(obs_rsp), 16);
        chk("max_last", 32'(obs_last), 1);
        repeat (2) cycle();

        // randomized traffic with stray read beats and random lock bits
        rnd_req = 1; stray = 1; rv_min = 0; rv_max = 3; d0 = done_cnt;
        repeat (2000) cycle();
        rnd_req = 0; stray = 0; m_lock = '0;
        n = 0;
        while ((phase != 0 || m_req != 0) && n < 2000) begin cycle(); n++; end
        repeat (4) cycle();
        chk("rand_drain", 32'(phase == 0 && m_req == 0), 1);
        chk("rand_activity", 32'(done_cnt - d0 > 50), 1);

        // reset asserted while waiting on a len=7 burst
        rv_min = 2; rv_max = 3; rnd_ready = 0;
        set_cmd(0, 0, 32'h2000, 4'd7, '0, '0);
        n = 0;
        while (!(phase == 2 && beat >= 2) && n < 80) begin cycle(); n++; end
        chk("rst_reach_wait", 32'(phase == 2 && beat >= 2), 1);
        @(posedge clk); #1;
        resetn = 1'b0; m_req = '0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        drive_ports();
        #2;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_gnt", 32'(gnt), 0);
        chk("midrst_mem_valid", 32'(mem_valid), 0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        #2;
        chk("late_rvalid_rsp", 32'(rsp_valid), 0);
        chk("late_rvalid_busy", 32'(busy), 0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        model_reset();
        #2;
        chk("post_rst_busy", 32'(busy), 0);

        // round-robin pointer restarted: master 0 beats master 2
        rv_min = 0; rv_max = 1; gq.delete();
        set_cmd(0, 0, 32'h300, 4'd0, '0, '0);
        set_cmd(2, 0, 32'h500, 4'd0, '0, '0);
        repeat (14) cycle();
        chk("post_rst_first", 32'(gq_at(0)), 0);
        chk("post_rst_second", 32'(gq_at(1)), 2);
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
